divider: RTL and testbench

- Iterative 16-bit unsigned restoring divider. It is the inverse-operation companion of the pipelined 16x16 multiplier in the execute stage.
- It uses the same start/done handshake, so the ALU controller can stall on division exactly as it does on multiplication.
- Produces a 16-bit quotient and a 16-bit remainder in a fixed number of cycles, one quotient bit per cycle.

---
 rtl/divider_if.sv | 21 ++
 rtl/divider.sv | 150 +++++++++++++++
 tb/tb_divider.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/divider_if.sv
// Start/done handshake bundle between the ALU controller (master) and the divider (slave).
interface divider_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output a, b, start,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  a, b, start,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// Iterative restoring divider, one quotient bit per cycle, start/done handshake.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// BUSY  | one shift/trial-subtract per cycle, ITER cycles
// DONE  | results written to the output registers; done pulses on the next cycle
module divider #(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  divider_if.slave  bus
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             dbz;

  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] dbz_rem;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;
  logic             borrow;
  logic             ge;

  logic accept;
  logic last_iter;

  assign accept    = (state == IDLE) && bus.start;
  assign last_iter = (cnt == CW'(ITER - 1));

  // The partial remainder is always below the divisor, so its shifted form needs
  // one extra bit; when that bit is set the trial subtraction must succeed.
  assign shifted       = {rem, quo[WIDTH-1]};
  assign {borrow, sub} = {1'b0, shifted[WIDTH-1:0]} - {1'b0, dvs};
  assign ge            = shifted[WIDTH] | ~borrow;

`ifdef DIVIDER_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] a_raw;

  assign a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign q_fin   = neg_q ? -quo : quo;
  assign r_fin   = neg_r ? -rem : rem;
  assign dbz_rem = a_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      a_raw <= '0;
    end else if (accept) begin
      neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      neg_r <= bus.a[WIDTH-1];
      a_raw <= bus.a;
    end
  end
`else
  assign a_mag   = bus.a;
  assign b_mag   = bus.b;
  assign q_fin   = quo;
  assign r_fin   = rem;
  // With a zero divisor no iterations run, so the shift register still holds a.
  assign dbz_rem = quo;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = (bus.b == '0) ? DONE : BUSY;
      BUSY: if (last_iter) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
      dbz         <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            quo <= a_mag;
            dvs <= b_mag;
            rem <= '0;
            cnt <= '0;
            dbz <= (bus.b == '0);
          end
        end
        BUSY: begin
          rem <= ge ? sub : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        DONE: begin
          quotient_q  <= dbz ? '1 : q_fin;
          remainder_q <= dbz ? dbz_rem : r_fin;
          dbz_q       <= dbz;
          done_q      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.done        = done_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: driver pushes expected results, a negedge monitor checks them.
module tb_divider;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  divider_if #(.WIDTH(16)) bus ();

  divider #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          issued  = 0;
  int          ndone   = 0;
  logic [15:0] hold_q  = '0;
  logic [15:0] hold_r  = '0;
  logic        hold_z  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int acc);
    exp_t e;
`ifdef DIVIDER_SIGNED_EN
    int sa, sb_;
`endif
    e.acc = acc;
    if (b == 16'd0) begin
      e.q = 16'hFFFF;
      e.r = a;
      e.z = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa  = $signed(a);
      sb_ = $signed(b);
      e.q = 16'(sa / sb_);
      e.r = 16'(sa % sb_);
`else
      e.q = a / b;
      e.r = a % b;
`endif
      e.z = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          chk("done_without_request", bus.done, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          chk("quotient", bus.quotient, mon_e.q);
          chk("remainder", bus.remainder, mon_e.r);
          chk("div_by_zero", bus.div_by_zero, mon_e.z);
          chk("latency", cyc - mon_e.acc, mon_e.z ? 1 : 17);
          hold_q = mon_e.q;
          hold_r = mon_e.r;
          hold_z = mon_e.z;
        end
        ndone++;
      end else begin
        chk("hold_quotient", bus.quotient, hold_q);
        chk("hold_remainder", bus.remainder, hold_r);
        chk("hold_div_by_zero", bus.div_by_zero, hold_z);
      end
    end
  end

  task automatic wait_done(input int target);
    int t = 0;
    while (ndone < target && t < 60) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", (ndone >= target), 1'b1);
  endtask

  // Issue one start pulse; a/b are scrambled right after acceptance.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int busy_want);
    int nb = 0;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    issued++;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) nb++;
      @(negedge clk);
    end
    if (busy_want > 0) chk("busy_len", nb, busy_want);
    wait_done(issued);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    hold_q = '0;
    hold_r = '0;
    hold_z = 1'b0;
  endtask

  initial begin
    logic [15:0] ra, rb;
    int base;

    bus.a = '0;
    bus.b = '0;
    bus.start = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_quotient", bus.quotient, 16'd0);
    chk("reset_remainder", bus.remainder, 16'd0);

    run_op(16'd100, 16'd7, 17);
    run_op(16'hFFFF, 16'd1, 17);
    run_op(16'd5, 16'hFFFF, 17);
    run_op(16'd1234, 16'd0, 1);

    // Held start: back-to-back accepts every 18 cycles, a/b toggled mid-operation.
    @(negedge clk);
    bus.a = 16'd50;
    bus.b = 16'd5;
    bus.start = 1'b1;
    base = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      sb.push_back(model(16'd50, 16'd5, base + 18 * k));
      issued++;
      @(negedge clk);
      if (k == 2) bus.start = 1'b0;
      repeat (15) begin
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        @(negedge clk);
      end
      bus.a = 16'd50;
      bus.b = 16'd5;
      @(negedge clk);
      @(negedge clk);
    end
    wait_done(issued);

    // Reset in the middle of an operation: aborted, no done.
    @(negedge clk);
    bus.a = 16'd1000;
    bus.b = 16'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    do_reset();
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_quotient", bus.quotient, 16'd0);
    chk("abort_remainder", bus.remainder, 16'd0);
    chk("abort_div_by_zero", bus.div_by_zero, 1'b0);
    repeat (25) @(negedge clk);
    run_op(16'd9, 16'd4, 17);

    // Reset and start together: reset wins.
    @(negedge clk);
    do_reset();
    bus.a = 16'd3;
    bus.b = 16'd1;
    bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    chk("reset_vs_start_busy", bus.busy, 1'b0);
    repeat (20) @(negedge clk);

`ifdef DIVIDER_SIGNED_EN
    run_op(16'hFFF9, 16'd2, 17);
    run_op(16'h8000, 16'hFFFF, 17);
    run_op(16'd7, 16'hFFFE, 17);
`endif

    for (int n = 0; n < 40; n++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = 16'd0;
        1:       rb = 16'($urandom_range(1, 15));
        default: rb = 16'($urandom);
      endcase
      run_op(ra, rb, rb == 16'd0 ? 1 : 17);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
